rvvi_tx_arbiter: RTL and testbench

- Frame-atomic arbiter that shares one 32-bit word-stream write channel into the Ethernet MAC between two frame sources.
  - Source 0: the RVVI trace packetizer.
  - Source 1: the host control/ack frame generator.
- Grants whole frames only, never interleaves words, and enforces a programmable inter-frame gap.
- Sits between the packetizers and the MAC TX FIFO, in the m_axi_aclk domain.

---
 rtl/cvw.sv | 13 +
 rtl/counter.sv | 25 ++
 rtl/ifg_timer.sv | 27 ++
 rtl/rvvi_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rvvi_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cvw.sv
// Shared definitions for the RVVI TX frame arbiter: FSM state encoding and source count.
package cvw;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  localparam int NUM_SOURCES = 2;

endpackage

// File: rtl/counter.sv
// Saturating up-counter with a synchronous clear; it holds at MAX instead of wrapping.
module counter #(
  parameter int MAX   = 512,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (srst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != WIDTH'(MAX))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ifg_timer.sv
// Loadable down-counter for the inter-frame gap; o_done flags the final gap cycle (count == 1).
module ifg_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Frame-atomic two-source arbiter in front of the MAC TX word channel, with inter-frame gap.
// Optional per-source frame and contention counters are enabled by defining RVVI_ARB_STATS_EN.
module rvvi_tx_arbiter
  import cvw::*;
#(
  parameter int S1_PRIORITY     = 0,
  parameter int MAX_FRAME_WORDS = 512,
  parameter int GAP_WIDTH       = 32
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_areset,
  input  logic [31:0]          S0Wdata,
  input  logic [3:0]           S0Wstrb,
  input  logic                 S0Wlast,
  input  logic                 S0Wvalid,
  output logic                 S0Wready,
  input  logic [31:0]          S1Wdata,
  input  logic [3:0]           S1Wstrb,
  input  logic                 S1Wlast,
  input  logic                 S1Wvalid,
  output logic                 S1Wready,
  output logic [31:0]          MWdata,
  output logic [3:0]           MWstrb,
  output logic                 MWlast,
  output logic                 MWvalid,
  input  logic                 MWready,
  input  logic [GAP_WIDTH-1:0] GapCycles,
  output logic [1:0]           Grant,
  output logic                 Busy,
`ifdef RVVI_ARB_STATS_EN
  output logic [31:0]          S0FrameCount,
  output logic [31:0]          S1FrameCount,
  output logic [31:0]          ContentionCount,
`endif
  output logic                 FrameErr
);

  localparam int CNT_W = $clog2(MAX_FRAME_WORDS + 1);

  arb_state_t           r_state;
  logic                 r_last_grant;
  logic                 r_frame_err;
  logic [1:0]           r_grant;
  logic                 r_busy;
  logic [GAP_WIDTH-1:0] r_gap_shadow;

  logic                 w_xfer;
  logic                 w_frame_end;
  logic                 w_pick1;
  logic                 w_gap_done;
  logic [CNT_W-1:0]     w_word_count;

  // Word pass-through from the granted source; everything is quiet outside a grant.
  always_comb begin
    MWdata   = '0;
    MWstrb   = '0;
    MWlast   = 1'b0;
    MWvalid  = 1'b0;
    S0Wready = 1'b0;
    S1Wready = 1'b0;
    case (r_state)
      GRANT0: begin
        MWdata   = S0Wdata;
        MWstrb   = S0Wstrb;
        MWlast   = S0Wlast;
        MWvalid  = S0Wvalid;
        S0Wready = MWready;
      end
      GRANT1: begin
        MWdata   = S1Wdata;
        MWstrb   = S1Wstrb;
        MWlast   = S1Wlast;
        MWvalid  = S1Wvalid;
        S1Wready = MWready;
      end
      default: ;
    endcase
  end

  assign w_xfer      = MWvalid & MWready;
  assign w_frame_end = w_xfer & MWlast;

  // Source 1 wins when alone, when it has priority, or when source 0 had the last grant.
  assign w_pick1 = S1Wvalid & (~S0Wvalid | (S1_PRIORITY != 0) | ~r_last_grant);

  counter #(
    .MAX   (MAX_FRAME_WORDS),
    .WIDTH (CNT_W)
  ) u_word_cnt (
    .clk     (m_axi_aclk),
    .srst    (m_axi_areset),
    .i_clr   (w_frame_end),
    .i_en    (w_xfer),
    .o_count (w_word_count)
  );

  ifg_timer #(
    .W (GAP_WIDTH)
  ) u_ifg (
    .clk        (m_axi_aclk),
    .srst       (m_axi_areset),
    .i_load     (w_frame_end),
    .i_load_val (r_gap_shadow),
    .i_en       (r_state == GAP),
    .o_done     (w_gap_done)
  );

  // The gap length is captured when the frame is granted, so edits made while a frame
  // is in flight only take effect from the next frame onward.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_frame_err  <= 1'b0;
      r_grant      <= 2'b00;
      r_busy       <= 1'b0;
      r_gap_shadow <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (S0Wvalid || S1Wvalid) begin
            r_gap_shadow <= GapCycles;
            r_busy       <= 1'b1;
            if (w_pick1) begin
              r_state      <= GRANT1;
              r_last_grant <= 1'b1;
              r_grant      <= 2'b10;
            end else begin
              r_state      <= GRANT0;
              r_last_grant <= 1'b0;
              r_grant      <= 2'b01;
            end
          end
        end
        GRANT0, GRANT1: begin
          if (w_frame_end) begin
            r_grant <= 2'b00;
            if (r_gap_shadow == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (w_gap_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Runaway frame: the transfer that brings the count to the limit is not a last.
      if (w_xfer && !MWlast && (w_word_count >= CNT_W'(MAX_FRAME_WORDS - 1))) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign Grant    = r_grant;
  assign Busy     = r_busy;
  assign FrameErr = r_frame_err;

`ifdef RVVI_ARB_STATS_EN
  logic [31:0] r_s0_frames;
  logic [31:0] r_s1_frames;
  logic [31:0] r_contention;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_s0_frames  <= '0;
      r_s1_frames  <= '0;
      r_contention <= '0;
    end else begin
      if (w_frame_end && (r_state == GRANT0)) r_s0_frames <= r_s0_frames + 1'b1;
      if (w_frame_end && (r_state == GRANT1)) r_s1_frames <= r_s1_frames + 1'b1;
      if ((r_state == IDLE) && S0Wvalid && S1Wvalid) r_contention <= r_contention + 1'b1;
    end
  end

  assign S0FrameCount    = r_s0_frames;
  assign S1FrameCount    = r_s1_frames;
  assign ContentionCount = r_contention;
`endif

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Directed bench for rvvi_tx_arbiter: a round-robin instance and a source-1-priority instance share stimulus.
module tb_rvvi_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] s0_data, s1_data;
  logic [3:0]  s0_strb, s1_strb;
  logic        s0_last, s1_last, s0_valid, s1_valid;
  logic        mw_ready;
  logic [31:0] gap;

  logic [31:0] m_data, p_m_data;
  logic [3:0]  m_strb, p_m_strb;
  logic        m_last, m_valid, s0_ready, s1_ready, busy, ferr;
  logic        p_m_last, p_m_valid, p_s0_ready, p_s1_ready, p_busy, p_ferr;
  logic [1:0]  grant, p_grant;
`ifdef RVVI_ARB_STATS_EN
  logic [31:0] s0_fc, s1_fc, cont_c, p_s0_fc, p_s1_fc, p_cont_c;
`endif

  rvvi_tx_arbiter #(.S1_PRIORITY(0), .MAX_FRAME_WORDS(8), .GAP_WIDTH(32)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .S0Wdata(s0_data), .S0Wstrb(s0_strb), .S0Wlast(s0_last), .S0Wvalid(s0_valid), .S0Wready(s0_ready),
    .S1Wdata(s1_data), .S1Wstrb(s1_strb), .S1Wlast(s1_last), .S1Wvalid(s1_valid), .S1Wready(s1_ready),
    .MWdata(m_data), .MWstrb(m_strb), .MWlast(m_last), .MWvalid(m_valid), .MWready(mw_ready),
    .GapCycles(gap), .Grant(grant), .Busy(busy),
`ifdef RVVI_ARB_STATS_EN
    .S0FrameCount(s0_fc), .S1FrameCount(s1_fc), .ContentionCount(cont_c),
`endif
    .FrameErr(ferr)
  );

  rvvi_tx_arbiter #(.S1_PRIORITY(1), .MAX_FRAME_WORDS(8), .GAP_WIDTH(32)) dut_p (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .S0Wdata(s0_data), .S0Wstrb(s0_strb), .S0Wlast(s0_last), .S0Wvalid(s0_valid), .S0Wready(p_s0_ready),
    .S1Wdata(s1_data), .S1Wstrb(s1_strb), .S1Wlast(s1_last), .S1Wvalid(s1_valid), .S1Wready(p_s1_ready),
    .MWdata(p_m_data), .MWstrb(p_m_strb), .MWlast(p_m_last), .MWvalid(p_m_valid), .MWready(mw_ready),
    .GapCycles(gap), .Grant(p_grant), .Busy(p_busy),
`ifdef RVVI_ARB_STATS_EN
    .S0FrameCount(p_s0_fc), .S1FrameCount(p_s1_fc), .ContentionCount(p_cont_c),
`endif
    .FrameErr(p_ferr)
  );

  int checks   = 0;
  int failures = 0;

  // Source models: frames still to send, frame length, current word, frames completed.
  int frames_left[2];
  int flen[2];
  int idx[2];
  int frm[2];
  bit use_p;
  int rr_g[17];
  int pr_g[10];

  function automatic logic [31:0] mk(input int s, input int f, input int i);
    return {8'(s), 8'(f), 16'(i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_valid = frames_left[0] > 0;
    s0_data  = mk(0, frm[0], idx[0]);
    s0_strb  = s0_valid ? 4'hF : 4'h0;
    s0_last  = s0_valid && (idx[0] == flen[0] - 1);
    s1_valid = frames_left[1] > 0;
    s1_data  = mk(1, frm[1], idx[1]);
    s1_strb  = s1_valid ? 4'hF : 4'h0;
    s1_last  = s1_valid && (idx[1] == flen[1] - 1);
  endtask

  task automatic advance(input int s);
    if (idx[s] == flen[s] - 1) begin
      idx[s] = 0;
      frm[s]++;
      frames_left[s]--;
    end else begin
      idx[s]++;
    end
  endtask

  task automatic tick();
    bit x0, x1;
    x0 = s0_valid && (use_p ? p_s0_ready : s0_ready);
    x1 = s1_valid && (use_p ? p_s1_ready : s1_ready);
    @(posedge clk);
    #1;
    if (x0) advance(0);
    if (x1) advance(1);
    drive();
    #1;
  endtask

  task automatic do_reset();
    for (int s = 0; s < 2; s++) begin
      frames_left[s] = 0;
      idx[s] = 0;
      frm[s] = 0;
      flen[s] = 1;
    end
    drive();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rr_g = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0, 2, 2, 2, 0};
    pr_g = '{0, 2, 2, 0, 2, 2, 0, 1, 1, 0};
    use_p = 1'b0;
    mw_ready = 1'b1;
    gap = 32'd0;
    rst = 1'b1;
    do_reset();

    // Reset state
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_mwvalid", m_valid, 1'b0);
    chk("rst_mwdata", m_data, 32'd0);
    chk("rst_mwstrb", m_strb, 4'd0);
    chk("rst_s0ready", s0_ready, 1'b0);
    chk("rst_s1ready", s1_ready, 1'b0);

    // Single source 0, 4 words, no gap
    flen[0] = 4; frames_left[0] = 1; drive(); #1;
    chk("t2_idle_mwvalid", m_valid, 1'b0);
    chk("t2_idle_grant", grant, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_mwvalid", m_valid, 1'b1);
      chk("t2_grant", grant, 2'b01);
      chk("t2_mwdata", m_data, mk(0, 0, i));
      chk("t2_mwlast", m_last, (i == 3) ? 1'b1 : 1'b0);
      chk("t2_s0ready", s0_ready, 1'b1);
      chk("t2_s1ready", s1_ready, 1'b0);
    end
    tick();
    chk("t2_end_grant", grant, 2'b00);
    chk("t2_end_busy", busy, 1'b0);
    chk("t2_end_mwvalid", m_valid, 1'b0);

    // Round-robin contention, two 3-word frames per source
    do_reset();
    flen[0] = 3; flen[1] = 3; frames_left[0] = 2; frames_left[1] = 2; drive(); #1;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) tick();
      chk("t3_grant", grant, rr_g[c]);
      if (rr_g[c] != 0) begin
        chk("t3_mwdata", m_data, mk(rr_g[c] - 1, (c >= 9) ? 1 : 0, (c - 1) % 4));
        chk("t3_mwlast", m_last, ((c - 1) % 4 == 2) ? 1'b1 : 1'b0);
      end
    end

    // Source 1 priority instance
    do_reset();
    use_p = 1'b1;
    flen[0] = 2; flen[1] = 2; frames_left[0] = 1; frames_left[1] = 2; drive(); #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      chk("t4_pgrant", p_grant, pr_g[c]);
      if (c == 7) chk("t4_pdata", p_m_data, mk(0, 0, 0));
    end
    use_p = 1'b0;

    // Backpressure with a 5-cycle gap; GapCycles edited mid-frame
    do_reset();
    gap = 32'd5; flen[0] = 4; frames_left[0] = 1; mw_ready = 1'b1; drive(); #1;
    for (int g = 0; g < 7; g++) begin
      tick();
      mw_ready = (g % 2 == 0);
      if (g == 3) gap = 32'd9;
      #1;
      chk("t5_s0ready", s0_ready, (g % 2 == 0) ? 1'b1 : 1'b0);
      chk("t5_mwdata", m_data, mk(0, 0, (g + 1) / 2));
      chk("t5_grant", grant, 2'b01);
    end
    frames_left[1] = 1; flen[1] = 1; mw_ready = 1'b1; drive(); #1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_gap_busy", busy, 1'b1);
      chk("t5_gap_grant", grant, 2'b00);
      chk("t5_gap_s0ready", s0_ready, 1'b0);
      chk("t5_gap_s1ready", s1_ready, 1'b0);
      chk("t5_gap_mwvalid", m_valid, 1'b0);
    end
    tick();
    chk("t5_idle_busy", busy, 1'b0);
    tick();
    chk("t5_next_grant", grant, 2'b10);
    chk("t5_next_data", m_data, mk(1, 0, 0));

    // Runaway frame: 10 words without last, last on word 11
    do_reset();
    gap = 32'd0; flen[1] = 11; frames_left[1] = 1; drive(); #1;
    chk("t6_ferr_start", ferr, 1'b0);
    for (int g = 0; g < 11; g++) begin
      tick();
      chk("t6_mwvalid", m_valid, 1'b1);
      chk("t6_mwdata", m_data, mk(1, 0, g));
      chk("t6_mwlast", m_last, (g == 10) ? 1'b1 : 1'b0);
      chk("t6_ferr", ferr, (g >= 8) ? 1'b1 : 1'b0);
    end
    tick();
    chk("t6_end_grant", grant, 2'b00);
    chk("t6_ferr_sticky", ferr, 1'b1);

    // Reset after 2 of 6 words
    flen[0] = 6; frames_left[0] = 1; drive(); #1;
    tick();
    tick();
    tick();
    chk("t7_pre_data", m_data, mk(0, 0, 2));
    rst = 1'b1;
    tick();
    chk("t7_grant", grant, 2'b00);
    chk("t7_mwvalid", m_valid, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_ferr", ferr, 1'b0);
    chk("t7_s0ready", s0_ready, 1'b0);
    rst = 1'b0;
    idx[0] = 0; flen[0] = 1; flen[1] = 1; frames_left[0] = 1; frames_left[1] = 1;
    drive(); #1;
    tick();
    chk("t7_lastgrant_grant", grant, 2'b01);
    chk("t7_lastgrant_data", m_data, mk(0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
